// File: rtl/adder_tree_pkg.sv
// Shared constants and FSM state type for the adder tree sequencer.
// Contents: operand count, tree depth, counter/slot widths, seq_state_t.
package adder_tree_pkg;
  localparam int N_OPS  = 8;
  localparam int LEVELS = 3;
  localparam int CNT_W  = $clog2(N_OPS + 1);
  localparam int SLOT_W = $clog2(N_OPS);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    SUM  = 2'd1,
    PIPE = 2'd2,
    HOLD = 2'd3
  } seq_state_t;
endpackage

// File: rtl/adder_tree_8.sv
// Combinational 3-level pairwise tree over eight unsigned operands.
// Ports: ops (8 operands), lvl2 (two level-2 partial sums), sum (full sum).
module adder_tree_8
  import adder_tree_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [N_OPS-1:0][WIDTH-1:0] ops,
  output logic [1:0][WIDTH+1:0]       lvl2,
  output logic [WIDTH+LEVELS-1:0]     sum
);
  logic [3:0][WIDTH:0] lvl1;

  // Each level zero-extends by one bit so no carry is lost.
  always_comb begin
    lvl1 = '0;
    lvl2 = '0;
    for (int i = 0; i < 4; i++)
      lvl1[i] = {1'b0, ops[2*i]} + {1'b0, ops[2*i+1]};
    for (int i = 0; i < 2; i++)
      lvl2[i] = {1'b0, lvl1[2*i]} + {1'b0, lvl1[2*i+1]};
    sum = {1'b0, lvl2[0]} + {1'b0, lvl2[1]};
  end
endmodule

// File: rtl/adder_tree_sequencer.sv
// Frames a serial operand stream into 8 slots, sums them, returns result.
// Ports: clk, rst_n, in_* (valid/ready/data/last), out_* (valid/ready/sum/count).
// Option: define ADDER_TREE_PIPE_EN to register the level-2 partial sums.
module adder_tree_sequencer
  import adder_tree_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH+LEVELS-1:0] out_sum,
  output logic [CNT_W-1:0]        out_count
);
  localparam int SUM_W = WIDTH + LEVELS;

  seq_state_t                   state;
  logic [CNT_W-1:0]             cnt;
  logic [N_OPS-1:0][WIDTH-1:0]  slots;
  logic [1:0][WIDTH+1:0]        lvl2;
  logic [SUM_W-1:0]             tree_sum;
  logic                         beat;
  logic                         hs;
  logic                         frame_end;

  // Handshake readiness is a pure function of state.
  assign in_ready  = (state == FILL);
  assign out_valid = (state == HOLD);
  assign beat      = in_valid && in_ready;
  assign hs        = out_valid && out_ready;
  assign frame_end = in_last || (cnt == CNT_W'(N_OPS - 1));

  adder_tree_8 #(
    .WIDTH (WIDTH)
  ) u_tree (
    .ops  (slots),
    .lvl2 (lvl2),
    .sum  (tree_sum)
  );

`ifdef ADDER_TREE_PIPE_EN
  logic [1:0][WIDTH+1:0] pipe_l2;
  logic [SUM_W-1:0]      pipe_sum;
  logic                  unused_tree_sum;

  assign unused_tree_sum = ^tree_sum;
  // Final tree level runs from the registered partial sums.
  assign pipe_sum = {1'b0, pipe_l2[0]} + {1'b0, pipe_l2[1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pipe_l2 <= '0;
    else if (state == SUM)
      pipe_l2 <= lvl2;
  end
`else
  logic unused_lvl2;
  assign unused_lvl2 = ^lvl2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      cnt       <= '0;
      slots     <= '0;
      out_sum   <= '0;
      out_count <= '0;
    end else begin
      unique case (state)
        FILL: begin
          if (beat) begin
            slots[cnt[SLOT_W-1:0]] <= in_data;
            cnt <= cnt + 1'b1;
            if (frame_end)
              state <= SUM;
          end
        end
        SUM: begin
          out_count <= cnt;
`ifdef ADDER_TREE_PIPE_EN
          state     <= PIPE;
`else
          out_sum   <= tree_sum;
          state     <= HOLD;
`endif
        end
        PIPE: begin
`ifdef ADDER_TREE_PIPE_EN
          out_sum <= pipe_sum;
          state   <= HOLD;
`else
          state   <= FILL;
`endif
        end
        HOLD: begin
          // Clearing slots keeps short frames from seeing stale operands.
          if (hs) begin
            slots <= '0;
            cnt   <= '0;
            state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule
